// File: rtl/freq_scale_pkg.sv
// Shared definitions for freq_scale_ctrl: step codes, repeat FSM states and
// the Scale stepping / Tick period helpers.
package freq_scale_pkg;

  localparam logic [1:0] STEP_NONE = 2'd0;
  localparam logic [1:0] STEP_UP   = 2'd1;
  localparam logic [1:0] STEP_DN   = 2'd2;

  typedef enum logic [1:0] {
    REP_IDLE  = 2'd0,
    REP_DELAY = 2'd1,
    REP_RATE  = 2'd2
  } rep_state_t;

  // Wide integer arithmetic so stepping past either bound never overflows silently.
  function automatic int next_scale(input int cur, input logic [1:0] step,
                                    input int scale_min, input int scale_max,
                                    input bit wrap);
    int n;
    n = cur;
    if (step == STEP_UP) begin
      if (cur >= scale_max) n = wrap ? scale_min : scale_max;
      else                  n = cur + 1;
    end else if (step == STEP_DN) begin
      if (cur <= scale_min) n = wrap ? scale_max : scale_min;
      else                  n = cur - 1;
    end
    return n;
  endfunction

  function automatic int tick_period(input int scale, input int scale_max,
                                     input int base_div);
    return base_div * (scale_max - scale + 1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus a prev flop for one asynchronous push button.
// Edges are suppressed until prev holds a genuine post-reset sample.
module btn_sync_edge (
  input  logic sysclk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press,
  output logic released
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [2:0] vld;

  // vld travels alongside the data so a button held through reset never looks like a fresh press.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      vld   <= 3'b000;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      vld   <= {vld[1:0], 1'b1};
    end
  end

  assign level    = sync2;
  assign press    = sync2 & ~prev & vld[2];
  assign released = ~sync2 & prev & vld[2];

endmodule

// File: rtl/freq_scale_ctrl.sv
// Plus/Minus driven Scale register with a Tick strobe whose period tracks Scale.
// Optional hold-to-repeat stepping is built when FREQ_SCALE_AUTO_REPEAT_EN is defined.
module freq_scale_ctrl
  import freq_scale_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int SCALE_MIN   = 0,
  parameter int SCALE_MAX   = 63,
  parameter int SCALE_INIT  = 32,
  parameter int WRAP        = 0,
  parameter int BASE_DIV    = 2,
  parameter int REPEAT_DLY  = 16,
  parameter int REPEAT_RATE = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             Plus,
  input  logic             Minus,
  output logic [WIDTH-1:0] Scale,
  output logic             Tick,
  output logic             AtLimit
);

  localparam int CNT_W = $clog2(BASE_DIV * (SCALE_MAX - SCALE_MIN + 1));
  localparam logic INIT_AT_LIMIT = (SCALE_INIT == SCALE_MIN) || (SCALE_INIT == SCALE_MAX);

  logic             p_lvl, p_press, p_rel;
  logic             m_lvl, m_press, m_rel;
  logic [1:0]       press_step;
  logic [1:0]       step;
  logic [WIDTH-1:0] scale_nxt;
  logic [CNT_W-1:0] count;
  int               period;

  btn_sync_edge u_plus (
    .sysclk   (sysclk),
    .reset    (reset),
    .btn      (Plus),
    .level    (p_lvl),
    .press    (p_press),
    .released (p_rel)
  );

  btn_sync_edge u_minus (
    .sysclk   (sysclk),
    .reset    (reset),
    .btn      (Minus),
    .level    (m_lvl),
    .press    (m_press),
    .released (m_rel)
  );

  // Simultaneous presses cancel; a press while the other button is held still counts.
  always_comb begin
    press_step = STEP_NONE;
    if (p_press && !m_press)      press_step = STEP_UP;
    else if (m_press && !p_press) press_step = STEP_DN;
  end

`ifdef FREQ_SCALE_AUTO_REPEAT_EN
  // state     | meaning
  // REP_IDLE  | no single button being held after a press
  // REP_DELAY | counting REPEAT_DLY cycles since the press
  // REP_RATE  | stepping once every REPEAT_RATE cycles while held
  localparam int REP_MAXC = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RCW      = $clog2(REP_MAXC + 1);

  rep_state_t     rep_state, rep_state_nxt;
  logic [1:0]     rep_dir, rep_dir_nxt;
  logic [RCW-1:0] rep_cnt, rep_cnt_nxt;
  logic           held;
  logic           rpt_fire;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rep_state <= REP_IDLE;
      rep_dir   <= STEP_NONE;
      rep_cnt   <= '0;
    end else begin
      rep_state <= rep_state_nxt;
      rep_dir   <= rep_dir_nxt;
      rep_cnt   <= rep_cnt_nxt;
    end
  end

  always_comb begin
    rep_state_nxt = rep_state;
    rep_dir_nxt   = rep_dir;
    rep_cnt_nxt   = rep_cnt;
    rpt_fire      = 1'b0;
    held          = (rep_dir == STEP_UP) ? (p_lvl & ~m_lvl) : (m_lvl & ~p_lvl);
    if (press_step != STEP_NONE) begin
      rep_state_nxt = REP_DELAY;
      rep_dir_nxt   = press_step;
      rep_cnt_nxt   = RCW'(1);
    end else if (rep_state != REP_IDLE) begin
      if (!held || p_rel || m_rel) begin
        rep_state_nxt = REP_IDLE;
        rep_cnt_nxt   = '0;
      end else if (int'(rep_cnt) == ((rep_state == REP_DELAY) ? REPEAT_DLY : REPEAT_RATE)) begin
        rpt_fire      = 1'b1;
        rep_state_nxt = REP_RATE;
        rep_cnt_nxt   = RCW'(1);
      end else begin
        rep_cnt_nxt   = rep_cnt + 1'b1;
      end
    end
  end

  assign step = (press_step != STEP_NONE) ? press_step :
                (rpt_fire ? rep_dir : STEP_NONE);
`else
  logic unused_btn;

  assign unused_btn = p_lvl ^ m_lvl ^ p_rel ^ m_rel ^ ((REPEAT_DLY + REPEAT_RATE) != 0);
  assign step       = press_step;
`endif

  assign scale_nxt = WIDTH'(next_scale(int'(Scale), step, SCALE_MIN, SCALE_MAX, WRAP != 0));
  assign period    = tick_period(int'(Scale), SCALE_MAX, BASE_DIV);

  // A count already past a freshly shortened period fires Tick on the next edge.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      Scale   <= WIDTH'(SCALE_INIT);
      AtLimit <= INIT_AT_LIMIT;
      Tick    <= 1'b0;
      count   <= '0;
    end else begin
      Scale   <= scale_nxt;
      AtLimit <= (int'(scale_nxt) == SCALE_MIN) || (int'(scale_nxt) == SCALE_MAX);
      if (int'(count) >= period - 1) begin
        Tick  <= 1'b1;
        count <= '0;
      end else begin
        Tick  <= 1'b0;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_scale_ctrl.sv
// Scoreboard bench for freq_scale_ctrl: a saturating and a wrapping instance
// share stimulus and are checked every cycle against an event-level model.
module tb_freq_scale_ctrl;

  localparam int W     = 6;
  localparam int SMIN  = 0;
  localparam int SMAX  = 63;
  localparam int SINIT = 32;
  localparam int BDIV  = 2;
  localparam int RDLY  = 16;
  localparam int RRATE = 4;
  localparam int NMAX  = 20000;

  logic         sysclk = 1'b0;
  logic         reset  = 1'b1;
  logic         Plus   = 1'b0;
  logic         Minus  = 1'b0;
  logic [W-1:0] scale0, scale1;
  logic         tick0, tick1, lim0, lim1;

  always #10 sysclk = ~sysclk;

  freq_scale_ctrl #(.WIDTH(W), .SCALE_MIN(SMIN), .SCALE_MAX(SMAX), .SCALE_INIT(SINIT),
                    .WRAP(0), .BASE_DIV(BDIV), .REPEAT_DLY(RDLY), .REPEAT_RATE(RRATE))
  dut0 (.sysclk(sysclk), .reset(reset), .Plus(Plus), .Minus(Minus),
        .Scale(scale0), .Tick(tick0), .AtLimit(lim0));

  freq_scale_ctrl #(.WIDTH(W), .SCALE_MIN(SMIN), .SCALE_MAX(SMAX), .SCALE_INIT(SINIT),
                    .WRAP(1), .BASE_DIV(BDIV), .REPEAT_DLY(RDLY), .REPEAT_RATE(RRATE))
  dut1 (.sysclk(sysclk), .reset(reset), .Plus(Plus), .Minus(Minus),
        .Scale(scale1), .Tick(tick1), .AtLimit(lim1));

  typedef struct {
    int n;
    int s0;
    int s1;
    bit a0;
    bit a1;
    bit t0;
    bit t1;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t push_e;
  int   checks = 0;
  int   errors = 0;

  bit   ph[NMAX];
  bit   mh[NMAX];
  int   edge_n   = 0;
  int   last_rst = 0;
  int   m_scale[2];
  int   m_cnt[2];
  bit   m_tick[2];
  int   rep_btn  = 0;
  int   rep_age  = 0;
  int   rep_next = 0;

  task automatic chk(input string nm, input int n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
    end
  endtask

  // A button counts as pressed at edge e when it was sampled low then high
  // two edges earlier, and the low sample was taken after the last reset.
  function automatic bit rose(input int e, input bit is_plus);
    bit h2, h3;
    if (e - 3 <= last_rst) return 1'b0;
    h2 = is_plus ? ph[e-2] : mh[e-2];
    h3 = is_plus ? ph[e-3] : mh[e-3];
    return h2 && !h3;
  endfunction

  function automatic int bump(input int s, input int step, input bit wrap);
    if (step > 0) return (s == SMAX) ? (wrap ? SMIN : SMAX) : s + 1;
    if (step < 0) return (s == SMIN) ? (wrap ? SMAX : SMIN) : s - 1;
    return s;
  endfunction

  task automatic model_edge();
    int step, period;
    bit pp, mp;
`ifdef FREQ_SCALE_AUTO_REPEAT_EN
    bit held;
`endif
    ph[edge_n] = Plus;
    mh[edge_n] = Minus;
    if (reset) begin
      last_rst = edge_n;
      rep_btn  = 0;
      for (int k = 0; k < 2; k++) begin
        m_scale[k] = SINIT;
        m_cnt[k]   = 0;
        m_tick[k]  = 1'b0;
      end
    end else begin
      pp   = rose(edge_n, 1'b1);
      mp   = rose(edge_n, 1'b0);
      step = 0;
      if (pp && !mp)      step = 1;
      else if (mp && !pp) step = -1;
`ifdef FREQ_SCALE_AUTO_REPEAT_EN
      if (step != 0) begin
        rep_btn  = step;
        rep_age  = 0;
        rep_next = RDLY;
      end else if (rep_btn != 0) begin
        held = (rep_btn > 0) ? (ph[edge_n-2] && !mh[edge_n-2])
                             : (mh[edge_n-2] && !ph[edge_n-2]);
        rep_age++;
        if (!held) rep_btn = 0;
        else if (rep_age == rep_next) begin
          step     = rep_btn;
          rep_next = rep_next + RRATE;
        end
      end
`endif
      for (int k = 0; k < 2; k++) begin
        period = BDIV * (SMAX - m_scale[k] + 1);
        if (m_cnt[k] >= period - 1) begin
          m_tick[k] = 1'b1;
          m_cnt[k]  = 0;
        end else begin
          m_tick[k] = 1'b0;
          m_cnt[k]  = m_cnt[k] + 1;
        end
        m_scale[k] = bump(m_scale[k], step, k == 1);
      end
    end
    push_e.n  = edge_n;
    push_e.s0 = m_scale[0];
    push_e.s1 = m_scale[1];
    push_e.a0 = (m_scale[0] == SMIN) || (m_scale[0] == SMAX);
    push_e.a1 = (m_scale[1] == SMIN) || (m_scale[1] == SMAX);
    push_e.t0 = m_tick[0];
    push_e.t1 = m_tick[1];
    sbq.push_back(push_e);
    edge_n++;
  endtask

  task automatic cyc(input bit r, input bit p, input bit m);
    @(negedge sysclk);
    reset = r;
    Plus  = p;
    Minus = m;
    if (edge_n >= NMAX) begin
      $display("FAIL history overflow at edge %0d: got %0d expected below %0d", edge_n, edge_n, NMAX);
      $fatal(1);
    end
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    idle(4);
  endtask

  task automatic pulse_plus(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: every output edge must match the oldest queued expectation.
  initial begin
    forever begin
      @(posedge sysclk);
      #1;
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("scale_sat",   mon_e.n, int'(scale0), mon_e.s0);
        chk("atlimit_sat", mon_e.n, int'(lim0),   int'(mon_e.a0));
        chk("tick_sat",    mon_e.n, int'(tick0),  int'(mon_e.t0));
        chk("scale_wrap",  mon_e.n, int'(scale1), mon_e.s1);
        chk("atlimit_wrap",mon_e.n, int'(lim1),   int'(mon_e.a1));
        chk("tick_wrap",   mon_e.n, int'(tick1),  int'(mon_e.t1));
      end
    end
  end

  initial begin
    int len;
    bit rp, rm;

    do_reset();
    idle(140);

    pulse_plus(1);
    idle(5);
    pulse_plus(1);
    idle(130);

    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    idle(8);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    idle(10);

    do_reset();
    pulse_plus(31);
    pulse_plus(1);
    idle(12);
    @(posedge sysclk);
    #2;
    chk("sat_at_max",   edge_n, int'(scale0), 63);
    chk("sat_limit",    edge_n, int'(lim0),   1);
    chk("wrap_to_min",  edge_n, int'(scale1), 0);
    chk("wrap_limit",   edge_n, int'(lim1),   1);

    do_reset();
    pulse_plus(8);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0);
    @(posedge sysclk);
    #2;
    chk("held_thru_reset", edge_n, int'(scale0), SINIT);
    idle(3);
    pulse_plus(1);
    idle(8);

    do_reset();
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0);
    idle(10);

    for (int seg = 0; seg < 500; seg++) begin
      len = $urandom_range(1, 12);
      rp  = ($urandom_range(0, 1) == 1);
      rm  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) cyc(1'b1, rp, rm);
      for (int i = 0; i < len; i++) cyc(1'b0, rp, rm);
    end
    idle(10);

    @(posedge sysclk);
    #3;
    chk("scoreboard_drain", edge_n, sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
